hazard_ctrl: RTL

- Pipeline hazard controller and scoreboard that sequences the decode stage. It tracks in-flight register writes, so decode stalls on RAW hazards that forwarding cannot cover.
- It squashes the wrong-path instruction after a taken branch or JAL is resolved in decode.
- It freezes the pipeline while data memory is busy.
- It sits beside decode; its outputs drive the fetch/decode pipeline-register enables and the bubble insertion into execute.

---
 rtl/hazard_ctrl_pkg.sv | 27 ++
 rtl/hazard_ctrl_sat_counter.sv | 34 +++
 rtl/hazard_ctrl.sv | 200 ++++++++++++++++++++
 3 files changed

// File: rtl/hazard_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl_pkg
// Description : Shared types and constants for the decode-stage hazard
//               controller: result latencies, the scoreboard counter type
//               and the redirect FSM state encoding.
// Revision    : 1.0 - initial release
// ============================================================================
package hazard_ctrl_pkg;

   // Cycles after issue until a result can be forwarded back to decode.
   localparam int LAT_ALU_C  = 1;
   localparam int LAT_LOAD_C = 2;

   // Scoreboard counter: must be wide enough to hold LAT_LOAD_C.
   localparam int CNT_W_C = 2;
   typedef logic [CNT_W_C-1:0] sb_cnt_t;

   // Redirect FSM. HZ_REDIRECT lasts exactly one unfrozen cycle, during
   // which the wrong-path instruction sitting in decode is squashed.
   typedef enum logic [0:0] {
      HZ_RUN      = 1'b0,
      HZ_REDIRECT = 1'b1
   } hz_state_t;

endpackage : hazard_ctrl_pkg
`default_nettype wire

// File: rtl/hazard_ctrl_sat_counter.sv
`default_nettype none
// ============================================================================
// Module      : sat_counter
// Description : Free-running event counter that increments when en is high
//               and sticks at all-ones instead of wrapping.
// Ports       : clk     - clock
//               rst_n   - asynchronous active-low reset (clears count)
//               en      - count this cycle
//               count   - current count value (WIDTH bits)
// Revision    : 1.0 - initial release
// ============================================================================
module sat_counter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] count
);

   logic [WIDTH-1:0] r_count;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
      end else if (en && (r_count != {WIDTH{1'b1}})) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign count = r_count;

endmodule : sat_counter
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Decode-stage hazard controller and register scoreboard.
//               Tracks in-flight register writes with per-register countdown
//               counters, stalls decode on RAW hazards that forwarding cannot
//               yet cover, squashes the wrong-path instruction after a taken
//               branch/JAL resolved in decode, and freezes everything while
//               data memory is busy.
// Ports       : clk           - clock
//               reset_n       - asynchronous active-low reset
//               d_valid       - decode holds a real instruction
//               d_ra1/d_ra2   - source register indices
//               d_use1/d_use2 - instruction reads rs1 / rs2
//               d_dst, d_wen  - destination index and write enable
//               d_is_load     - instruction is a load
//               d_is_jump     - taken branch / JAL resolved in decode
//               mem_busy      - data memory not ready, pipeline frozen
//               stall_f       - hold fetch PC and fetch register
//               stall_d       - hold decode register
//               bubble_e      - insert a bubble into execute
//               flush_d       - squash the instruction in decode
//               busy_mask     - per-register "write in flight" flags
//               hazard_cycles - saturating count of bubble cycles
//               flush_count   - saturating count of redirect flushes
// Revision    : 1.0 - initial release
// ============================================================================
module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int LAT_ALU  = LAT_ALU_C,
   parameter int LAT_LOAD = LAT_LOAD_C,
   parameter int CNT_W    = $bits(sb_cnt_t),
   parameter int PERF_W   = 32
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              d_valid,
   input  logic [4:0]        d_ra1,
   input  logic [4:0]        d_ra2,
   input  logic              d_use1,
   input  logic              d_use2,
   input  logic [4:0]        d_dst,
   input  logic              d_wen,
   input  logic              d_is_load,
   input  logic              d_is_jump,
   input  logic              mem_busy,
   output logic              stall_f,
   output logic              stall_d,
   output logic              bubble_e,
   output logic              flush_d,
   output logic [31:0]       busy_mask,
   output logic [PERF_W-1:0] hazard_cycles,
   output logic [PERF_W-1:0] flush_count
);

   localparam logic [CNT_W-1:0] c_lat_alu  = CNT_W'(LAT_ALU);
   localparam logic [CNT_W-1:0] c_lat_load = CNT_W'(LAT_LOAD);

   hz_state_t   r_state;
   hz_state_t   w_state_nxt;

   logic [31:0]      w_busy;
   logic             w_eff_valid;
   logic             w_hazard;
   logic             w_issue;
   logic             w_sb_write;
   logic [CNT_W-1:0] w_sb_lat;
   logic             w_redirect;
   logic             w_stall;
   logic             w_bubble;
   logic             w_flush;

   // -------------------------------------------------------------------------
   // Redirect FSM: state register
   // -------------------------------------------------------------------------
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= HZ_RUN;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // -------------------------------------------------------------------------
   // Redirect FSM: next state and decode-stage control
   // -------------------------------------------------------------------------
   always_comb begin
      w_state_nxt = r_state;
      w_eff_valid = 1'b0;
      w_hazard    = 1'b0;
      w_issue     = 1'b0;
      w_sb_write  = 1'b0;
      w_sb_lat    = c_lat_alu;
      w_redirect  = 1'b0;
      w_flush     = 1'b0;
      w_stall     = 1'b0;
      w_bubble    = 1'b0;

      // Whatever sits in decode during REDIRECT is wrong-path: it never
      // raises a hazard and never touches the scoreboard.
      w_eff_valid = d_valid && (r_state == HZ_RUN);

      // x0 reads are always satisfied, regardless of scoreboard contents.
      w_hazard = w_eff_valid &&
                 ((d_use1 && (d_ra1 != 5'd0) && w_busy[d_ra1]) ||
                  (d_use2 && (d_ra2 != 5'd0) && w_busy[d_ra2]));

      w_issue    = w_eff_valid && !w_hazard && !mem_busy;
      w_sb_write = w_issue && d_wen && (d_dst != 5'd0);
      w_sb_lat   = d_is_load ? c_lat_load : c_lat_alu;

      // A stalled jump has not issued yet, so its redirect waits too.
      w_redirect = w_issue && d_is_jump;

      w_stall  = w_hazard || mem_busy;
      w_bubble = w_hazard && !mem_busy;
      w_flush  = (r_state == HZ_REDIRECT);

      case (r_state)
         HZ_RUN: begin
            if (w_redirect) begin
               w_state_nxt = HZ_REDIRECT;
            end
         end
         HZ_REDIRECT: begin
            // Stay put while frozen so the squash still lands on the
            // wrong-path instruction once memory releases.
            if (!mem_busy) begin
               w_state_nxt = HZ_RUN;
            end
         end
         default: begin
            w_state_nxt = HZ_RUN;
         end
      endcase
   end

   // -------------------------------------------------------------------------
   // Scoreboard: one countdown counter per architectural register.
   // x0 is hard-wired idle. A new write reloads the counter with its result
   // latency, overriding the decrement so a younger writer (WAW) wins.
   // -------------------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < 32; gi++) begin : g_sb
         if (gi == 0) begin : g_x0
            assign w_busy[gi] = 1'b0;
         end else begin : g_reg
            logic [CNT_W-1:0] r_cnt;

            always_ff @(posedge clk or negedge reset_n) begin
               if (!reset_n) begin
                  r_cnt <= '0;
               end else if (!mem_busy) begin
                  if (w_sb_write && (d_dst == 5'(gi))) begin
                     r_cnt <= w_sb_lat;
                  end else if (r_cnt != '0) begin
                     r_cnt <= r_cnt - 1'b1;
                  end
               end
            end

            assign w_busy[gi] = (r_cnt != '0);
         end
      end
   endgenerate

   // -------------------------------------------------------------------------
   // Performance counters
   // -------------------------------------------------------------------------
   sat_counter #(
      .WIDTH (PERF_W)
   ) u_hazard_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .en    (w_bubble),
      .count (hazard_cycles)
   );

   sat_counter #(
      .WIDTH (PERF_W)
   ) u_flush_cnt (
      .clk   (clk),
      .rst_n (reset_n),
      .en    (w_redirect),
      .count (flush_count)
   );

   // -------------------------------------------------------------------------
   // Outputs
   // -------------------------------------------------------------------------
   assign stall_f   = w_stall;
   assign stall_d   = w_stall;
   assign bubble_e  = w_bubble;
   assign flush_d   = w_flush;
   assign busy_mask = w_busy;

endmodule : hazard_ctrl
`default_nettype wire
